// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - IF/ID inputs, writeback port and ID/EX outputs of the decode stage
interface decode_cycle_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 5,
  parameter int GHR_W  = 4
);
  logic [31:0]       Instr_D;
  logic [PC_W-1:0]   Pc_D;
  logic              prediction_D;
  logic              hit_D;
  logic [GHR_W-1:0]  GHR_D;
  logic              ID_EX_flush;
  logic              WB_RegWrite;
  logic [4:0]        WB_WriteReg;
  logic [DATA_W-1:0] WB_WriteData;

  logic [5:0]        opcode_D;
  logic [DATA_W-1:0] targetAddress_D;
  logic [4:0]        rs_D;
  logic [4:0]        rt_D;

  logic              RegWrite_E;
  logic              MemRead_E;
  logic              MemWrite_E;
  logic              MemtoReg_E;
  logic              ALUSrc_E;
  logic              Link_E;
  logic              branch_E;
  logic              bne_E;
  logic              rtype_E;
  logic [1:0]        RegDst_E;
  logic [1:0]        ALUOp_E;
  logic [5:0]        functJR_E;
  logic [DATA_W-1:0] ReadData1_E;
  logic [DATA_W-1:0] ReadData2_E;
  logic [DATA_W-1:0] Imm_E;
  logic [4:0]        rs_E;
  logic [4:0]        rt_E;
  logic [4:0]        rd_E;
  logic [PC_W-1:0]   Pc_E;
  logic              prediction_E;
  logic              hit_E;
  logic [GHR_W-1:0]  Pc_Xor_GR_E;
  logic [5:0]        R31_E;

  modport master (
    input  Instr_D, Pc_D, prediction_D, hit_D, GHR_D, ID_EX_flush,
           WB_RegWrite, WB_WriteReg, WB_WriteData,
    output opcode_D, targetAddress_D, rs_D, rt_D,
           RegWrite_E, MemRead_E, MemWrite_E, MemtoReg_E, ALUSrc_E, Link_E,
           branch_E, bne_E, rtype_E, RegDst_E, ALUOp_E, functJR_E,
           ReadData1_E, ReadData2_E, Imm_E, rs_E, rt_E, rd_E, Pc_E,
           prediction_E, hit_E, Pc_Xor_GR_E, R31_E
  );

  modport slave (
    output Instr_D, Pc_D, prediction_D, hit_D, GHR_D, ID_EX_flush,
           WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  opcode_D, targetAddress_D, rs_D, rt_D,
           RegWrite_E, MemRead_E, MemWrite_E, MemtoReg_E, ALUSrc_E, Link_E,
           branch_E, bne_E, rtype_E, RegDst_E, ALUOp_E, functJR_E,
           ReadData1_E, ReadData2_E, Imm_E, rs_E, rt_E, rd_E, Pc_E,
           prediction_E, hit_E, Pc_Xor_GR_E, R31_E
  );
endinterface

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - ID stage: register file, control decode, branch/jump target and ID/EX register
module decode_cycle #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 5,
  parameter int GHR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  decode_cycle_if.master    bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [DATA_W-1:0] regs [32];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [5:0]        r31_lo;
  logic              wb_live;

  logic       rtype, reg_write, mem_read, mem_write, mem_to_reg, alu_src, link;
  logic       branch, bne;
  logic [1:0] reg_dst, alu_op;

  assign opcode = bus.Instr_D[31:26];
  assign funct  = bus.Instr_D[5:0];
  assign rs     = bus.Instr_D[25:21];
  assign rt     = bus.Instr_D[20:16];
  assign rd     = bus.Instr_D[15:11];
  assign imm    = {{(DATA_W-16){bus.Instr_D[15]}}, bus.Instr_D[15:0]};
  assign pc_ext = {{(DATA_W-PC_W){1'b0}}, bus.Pc_D};

  assign bus.opcode_D = opcode;
  assign bus.rs_D     = rs;
  assign bus.rt_D     = rt;

  // Writeback to a nonzero register is forwarded straight into the same-cycle reads.
  assign wb_live = bus.WB_RegWrite && (bus.WB_WriteReg != 5'd0);

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    r31_lo     = regs[31][5:0];
    if (wb_live && bus.WB_WriteReg == rs) read_data1 = bus.WB_WriteData;
    else if (rs != 5'd0)                  read_data1 = regs[rs];
    if (wb_live && bus.WB_WriteReg == rt) read_data2 = bus.WB_WriteData;
    else if (rt != 5'd0)                  read_data2 = regs[rt];
    if (wb_live && bus.WB_WriteReg == 5'd31) r31_lo = bus.WB_WriteData[5:0];
  end

  always_comb begin
    rtype      = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    link       = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    reg_dst    = 2'b00;
    alu_op     = 2'b00;
    // An all-zero word is the fetch bubble, not sll r0,r0,0.
    if (bus.Instr_D != 32'd0) begin
      case (opcode)
        OP_RTYPE: begin
          rtype     = 1'b1;
          reg_write = (funct != FN_JR);
          reg_dst   = 2'b01;
          alu_op    = 2'b10;
        end
        OP_ADDI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_LW: begin
          reg_write  = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
        end
        OP_SW: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BEQ: begin
          branch = 1'b1;
          alu_op = 2'b01;
        end
        OP_BNE: begin
          branch = 1'b1;
          bne    = 1'b1;
          alu_op = 2'b01;
        end
        OP_JAL: begin
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          link      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.targetAddress_D = '0;
    if (opcode == OP_BEQ || opcode == OP_BNE)
      bus.targetAddress_D = pc_ext + DATA_W'(1) + imm;
    else if (opcode == OP_J || opcode == OP_JAL)
      bus.targetAddress_D = {{(DATA_W-26){1'b0}}, bus.Instr_D[25:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[bus.WB_WriteReg] <= bus.WB_WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.RegWrite_E   <= 1'b0;
      bus.MemRead_E    <= 1'b0;
      bus.MemWrite_E   <= 1'b0;
      bus.MemtoReg_E   <= 1'b0;
      bus.ALUSrc_E     <= 1'b0;
      bus.Link_E       <= 1'b0;
      bus.branch_E     <= 1'b0;
      bus.bne_E        <= 1'b0;
      bus.rtype_E      <= 1'b0;
      bus.RegDst_E     <= 2'b00;
      bus.ALUOp_E      <= 2'b00;
      bus.functJR_E    <= 6'd0;
      bus.ReadData1_E  <= '0;
      bus.ReadData2_E  <= '0;
      bus.Imm_E        <= '0;
      bus.rs_E         <= 5'd0;
      bus.rt_E         <= 5'd0;
      bus.rd_E         <= 5'd0;
      bus.Pc_E         <= '0;
      bus.prediction_E <= 1'b0;
      bus.hit_E        <= 1'b0;
      bus.Pc_Xor_GR_E  <= '0;
      bus.R31_E        <= 6'd0;
    end else begin
      bus.ReadData1_E  <= read_data1;
      bus.ReadData2_E  <= read_data2;
      bus.Imm_E        <= imm;
      bus.rs_E         <= rs;
      bus.rt_E         <= rt;
      bus.rd_E         <= rd;
      bus.Pc_E         <= bus.Pc_D;
      bus.Pc_Xor_GR_E  <= bus.Pc_D[GHR_W-1:0] ^ bus.GHR_D;
      bus.R31_E        <= r31_lo;
      if (bus.ID_EX_flush) begin
        bus.RegWrite_E   <= 1'b0;
        bus.MemRead_E    <= 1'b0;
        bus.MemWrite_E   <= 1'b0;
        bus.MemtoReg_E   <= 1'b0;
        bus.ALUSrc_E     <= 1'b0;
        bus.Link_E       <= 1'b0;
        bus.branch_E     <= 1'b0;
        bus.bne_E        <= 1'b0;
        bus.rtype_E      <= 1'b0;
        bus.RegDst_E     <= 2'b00;
        bus.ALUOp_E      <= 2'b00;
        bus.functJR_E    <= 6'd0;
        bus.prediction_E <= 1'b0;
        bus.hit_E        <= 1'b0;
      end else begin
        bus.RegWrite_E   <= reg_write;
        bus.MemRead_E    <= mem_read;
        bus.MemWrite_E   <= mem_write;
        bus.MemtoReg_E   <= mem_to_reg;
        bus.ALUSrc_E     <= alu_src;
        bus.Link_E       <= link;
        bus.branch_E     <= branch;
        bus.bne_E        <= bne;
        bus.rtype_E      <= rtype;
        bus.RegDst_E     <= reg_dst;
        bus.ALUOp_E      <= alu_op;
        bus.functJR_E    <= funct;
        bus.prediction_E <= bus.prediction_D;
        bus.hit_E        <= bus.hit_D;
      end
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed self-checking bench for decode_cycle
module tb_decode_cycle;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] instr, input logic [4:0] pc,
                       input logic pred, input logic hit, input logic [3:0] ghr);
    bus.Instr_D      = instr;
    bus.Pc_D         = pc;
    bus.prediction_D = pred;
    bus.hit_D        = hit;
    bus.GHR_D        = ghr;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.WB_RegWrite  = en;
    bus.WB_WriteReg  = addr;
    bus.WB_WriteData = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.ID_EX_flush = 1'b0;
    set_d(32'd0, 5'd0, 1'b0, 1'b0, 4'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    check_eq("rst_regwrite", {31'd0, bus.RegWrite_E}, 32'd0);
    check_eq("rst_rd1", bus.ReadData1_E, 32'd0);

    // Release reset, bubble instruction
    reset = 1'b1;
    tick();
    check_eq("bubble_rtype", {31'd0, bus.rtype_E}, 32'd0);
    check_eq("bubble_regdst", {30'd0, bus.RegDst_E}, 32'd0);
    check_eq("bubble_rd1", bus.ReadData1_E, 32'd0);

    // add r3,r5,r5 with WB r5 bypass
    set_d(32'h00A51820, 5'd1, 1'b0, 1'b0, 4'd0);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check_eq("add_rs_D", {27'd0, bus.rs_D}, 32'd5);
    check_eq("add_opcode_D", {26'd0, bus.opcode_D}, 32'd0);
    tick();
    check_eq("add_rd1", bus.ReadData1_E, 32'hDEADBEEF);
    check_eq("add_rd2", bus.ReadData2_E, 32'hDEADBEEF);
    check_eq("add_regdst", {30'd0, bus.RegDst_E}, 32'd1);
    check_eq("add_rtype", {31'd0, bus.rtype_E}, 32'd1);
    check_eq("add_aluop", {30'd0, bus.ALUOp_E}, 32'd2);
    check_eq("add_rd_E", {27'd0, bus.rd_E}, 32'd3);

    // beq r5,r0,-4 at Pc 7
    set_wb(1'b0, 5'd0, 32'd0);
    set_d(32'h10A0FFFC, 5'd7, 1'b0, 1'b0, 4'd0);
    #1;
    check_eq("beq_target", bus.targetAddress_D, 32'd4);
    tick();
    check_eq("beq_branch", {31'd0, bus.branch_E}, 32'd1);
    check_eq("beq_bne", {31'd0, bus.bne_E}, 32'd0);
    check_eq("beq_imm", bus.Imm_E, 32'hFFFFFFFC);
    check_eq("beq_aluop", {30'd0, bus.ALUOp_E}, 32'd1);
    check_eq("beq_rd1_stored", bus.ReadData1_E, 32'hDEADBEEF);
    check_eq("beq_pc_E", {27'd0, bus.Pc_E}, 32'd7);

    // bne r1,r2,+3 at Pc 9, GHR 0101
    set_d(32'h14220003, 5'd9, 1'b1, 1'b1, 4'b0101);
    #1;
    check_eq("bne_target", bus.targetAddress_D, 32'd13);
    tick();
    check_eq("bne_xor", {28'd0, bus.Pc_Xor_GR_E}, 32'hC);
    check_eq("bne_bne", {31'd0, bus.bne_E}, 32'd1);
    check_eq("bne_branch", {31'd0, bus.branch_E}, 32'd1);
    check_eq("bne_pred", {31'd0, bus.prediction_E}, 32'd1);
    check_eq("bne_hit", {31'd0, bus.hit_E}, 32'd1);

    // lw flushed, WB r2 still lands
    set_d(32'h8C440008, 5'd10, 1'b1, 1'b1, 4'd0);
    set_wb(1'b1, 5'd2, 32'h000055AA);
    bus.ID_EX_flush = 1'b1;
    tick();
    check_eq("flush_regwrite", {31'd0, bus.RegWrite_E}, 32'd0);
    check_eq("flush_memread", {31'd0, bus.MemRead_E}, 32'd0);
    check_eq("flush_memtoreg", {31'd0, bus.MemtoReg_E}, 32'd0);
    check_eq("flush_alusrc", {31'd0, bus.ALUSrc_E}, 32'd0);
    check_eq("flush_pred", {31'd0, bus.prediction_E}, 32'd0);
    check_eq("flush_functjr", {26'd0, bus.functJR_E}, 32'd0);

    // Same lw without flush
    bus.ID_EX_flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("lw_regwrite", {31'd0, bus.RegWrite_E}, 32'd1);
    check_eq("lw_memread", {31'd0, bus.MemRead_E}, 32'd1);
    check_eq("lw_memtoreg", {31'd0, bus.MemtoReg_E}, 32'd1);
    check_eq("lw_alusrc", {31'd0, bus.ALUSrc_E}, 32'd1);
    check_eq("lw_regdst", {30'd0, bus.RegDst_E}, 32'd0);
    check_eq("lw_rd1_r2", bus.ReadData1_E, 32'h000055AA);

    // add r6,r2,r0 reads r2 from the file
    set_d(32'h00403020, 5'd11, 1'b0, 1'b0, 4'd0);
    tick();
    check_eq("r2_readback", bus.ReadData1_E, 32'h000055AA);
    check_eq("r2_rt_r0", bus.ReadData2_E, 32'd0);

    // Writes to r0 are discarded, including the bypass
    set_d(32'h00003820, 5'd12, 1'b0, 1'b0, 4'd0);
    set_wb(1'b1, 5'd0, 32'h00001234);
    tick();
    check_eq("r0_bypass", bus.ReadData1_E, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("r0_stored", bus.ReadData1_E, 32'd0);

    // jal 0x15 while WB writes r31
    set_d(32'h0C000015, 5'd13, 1'b0, 1'b0, 4'd0);
    set_wb(1'b1, 5'd31, 32'h1234562A);
    #1;
    check_eq("jal_target", bus.targetAddress_D, 32'h15);
    check_eq("jal_opcode_D", {26'd0, bus.opcode_D}, 32'd3);
    tick();
    check_eq("jal_regdst", {30'd0, bus.RegDst_E}, 32'd2);
    check_eq("jal_link", {31'd0, bus.Link_E}, 32'd1);
    check_eq("jal_regwrite", {31'd0, bus.RegWrite_E}, 32'd1);
    check_eq("jal_r31_bypass", {26'd0, bus.R31_E}, 32'h2A);

    // jr r31
    set_wb(1'b0, 5'd0, 32'd0);
    set_d(32'h03E00008, 5'd14, 1'b0, 1'b0, 4'd0);
    #1;
    check_eq("jr_target", bus.targetAddress_D, 32'd0);
    tick();
    check_eq("jr_regwrite", {31'd0, bus.RegWrite_E}, 32'd0);
    check_eq("jr_rtype", {31'd0, bus.rtype_E}, 32'd1);
    check_eq("jr_functjr", {26'd0, bus.functJR_E}, 32'h08);
    check_eq("jr_r31", {26'd0, bus.R31_E}, 32'h2A);
    check_eq("jr_rd1", bus.ReadData1_E, 32'h1234562A);

    // sw, j, unknown opcode
    set_d(32'hAC220004, 5'd15, 1'b0, 1'b0, 4'd0);
    tick();
    check_eq("sw_memwrite", {31'd0, bus.MemWrite_E}, 32'd1);
    check_eq("sw_regwrite", {31'd0, bus.RegWrite_E}, 32'd0);
    set_d(32'h08000100, 5'd16, 1'b0, 1'b0, 4'd0);
    #1;
    check_eq("j_target", bus.targetAddress_D, 32'h100);
    tick();
    check_eq("j_controls", {25'd0, bus.RegWrite_E, bus.MemWrite_E, bus.branch_E, bus.Link_E,
                            bus.RegDst_E, bus.rtype_E}, 32'd0);
    set_d(32'hFC000000, 5'd17, 1'b0, 1'b0, 4'd0);
    tick();
    check_eq("unk_controls", {25'd0, bus.RegWrite_E, bus.MemWrite_E, bus.branch_E, bus.ALUSrc_E,
                              bus.ALUOp_E, bus.rtype_E}, 32'd0);

    // addi r1,r0,-1 then reset mid-cycle
    set_d(32'h2001FFFF, 5'd18, 1'b0, 1'b0, 4'd0);
    tick();
    check_eq("addi_regwrite", {31'd0, bus.RegWrite_E}, 32'd1);
    check_eq("addi_alusrc", {31'd0, bus.ALUSrc_E}, 32'd1);
    check_eq("addi_imm", bus.Imm_E, 32'hFFFFFFFF);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_regwrite", {31'd0, bus.RegWrite_E}, 32'd0);
    check_eq("async_rst_imm", bus.Imm_E, 32'd0);
    tick();
    reset = 1'b1;
    set_d(32'h00A51820, 5'd19, 1'b0, 1'b0, 4'd0);
    tick();
    check_eq("post_rst_r5", bus.ReadData1_E, 32'd0);
    check_eq("post_rst_rtype", {31'd0, bus.rtype_E}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
